// File: rtl/typecm_tx_seq_if.sv
// Control/handshake bundle for the packet-type sequencer.
// master: control logic plus typecm_tx side; slave: the sequencer itself.
interface typecm_tx_seq_if #(
  parameter int DEPTH = 8,
  parameter int GAP_W = 8,
  parameter int CNT_W = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [3:0]       wr_btype;
  logic [AW:0]      seq_len;
  logic [GAP_W-1:0] gap;
  logic             loop;
  logic             start;
  logic             abort;
  logic             fs;
  logic             fd;
  logic [3:0]       btype;
  logic             busy;
  logic             done;
  logic             err_timeout;
  logic [CNT_W-1:0] pkt_cnt;

  modport master (
    output wr_en, wr_addr, wr_btype, seq_len, gap, loop, start, abort, fd,
    input  fs, btype, busy, done, err_timeout, pkt_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_btype, seq_len, gap, loop, start, abort, fd,
    output fs, btype, busy, done, err_timeout, pkt_cnt
  );
endinterface

// File: rtl/typecm_tx_seq.sv
// Programmable packet-type sequencer driving typecm_tx via fs/fd.
// Plays table entries in order, skipping BAG_INIT, with gap, loop, abort
// and fd timeout.
module typecm_tx_seq #(
  parameter int DEPTH   = 8,
  parameter int GAP_W   = 8,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  typecm_tx_seq_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0]  BAG_INIT = 4'b0000;
  localparam logic [AW:0] LEN_MAX  = (AW + 1)'(DEPTH);

  logic [2:0]       r_state;
  logic [3:0]       r_table [DEPTH];
  logic [AW-1:0]    r_idx;
  logic [AW:0]      r_len;
  logic [AW:0]      r_skip;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_loop;
  logic             r_abort;
  logic             r_turn;
  logic [TW-1:0]    r_to_cnt;
  logic [3:0]       r_btype;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [AW:0]      w_len_clamp;
  logic [3:0]       w_entry;
  logic             w_last;
  logic [AW-1:0]    w_idx_next;
  logic             w_to_hit;

  assign w_len_clamp = (bus.seq_len > LEN_MAX) ? LEN_MAX : bus.seq_len;
  assign w_entry     = r_table[r_idx];
  assign w_last      = ({1'b0, r_idx} == (r_len - 1'b1));
  assign w_idx_next  = w_last ? '0 : r_idx + 1'b1;
  assign w_to_hit    = (r_to_cnt == TW'(TIMEOUT - 1));

  assign bus.fs          = (r_state == S_SEND);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.btype       = r_btype;
  assign bus.done        = r_done;
  assign bus.err_timeout = r_err;
  assign bus.pkt_cnt     = r_cnt;

  // Table: cleared on reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_table[i] <= BAG_INIT;
    end else if ((r_state == S_IDLE) && bus.wr_en) begin
      r_table[bus.wr_addr] <= bus.wr_btype;
    end
  end

  // Sequencer FSM with counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_skip    <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_loop    <= 1'b0;
      r_abort   <= 1'b0;
      r_turn    <= 1'b0;
      r_to_cnt  <= '0;
      r_btype   <= BAG_INIT;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_len   <= w_len_clamp;
            r_gap   <= bus.gap;
            r_loop  <= bus.loop;
            r_abort <= 1'b0;
            r_skip  <= '0;
            r_turn  <= 1'b0;
            r_state <= (w_len_clamp == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          // After a packet, LOAD spends one turnaround cycle before its first
          // read so that fs re-rises gap+2 cycles after fd.
          if (bus.abort) begin
            r_state <= S_DONE;
          end else if (r_turn) begin
            r_turn <= 1'b0;
          end else if (w_entry == BAG_INIT) begin
            // A full pass of consecutive skips ends the run even when looping.
            if ((w_last && !r_loop) || (r_skip == (r_len - 1'b1))) begin
              r_state <= S_DONE;
            end else begin
              r_idx  <= w_idx_next;
              r_skip <= r_skip + 1'b1;
            end
          end else begin
            r_btype  <= w_entry;
            r_to_cnt <= '0;
            r_skip   <= '0;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.abort) r_abort <= 1'b1;
          if (bus.fd) begin
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            r_idx <= w_idx_next;
            if ((w_last && !r_loop) || r_abort || bus.abort) begin
              r_state <= S_DONE;
            end else if (r_gap == '0) begin
              r_state <= S_LOAD;
              r_turn  <= 1'b1;
            end else begin
              r_state   <= S_GAP;
              r_gap_cnt <= r_gap - 1'b1;
            end
          end else if (w_to_hit) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (bus.abort) begin
            r_state <= S_DONE;
          end else if (r_gap_cnt == '0) begin
            r_state <= S_LOAD;
            r_turn  <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_btype <= BAG_INIT;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
